// File: rtl/gcm_job_seq.sv
// Job sequencer in front of the GCM core: key/iv, AAD and payload strobes, byte masking, tag capture.
// Latency: every accepted command, block or core output shows up as a registered strobe one cycle later.
// Backpressure: cmd_ready_o only in IDLE, blk_ready_o only in AAD/DATA; the core side has no backpressure.
module gcm_job_seq #(
    parameter int LEN_W       = 16,
    parameter int TAG_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [127:0]     cmd_key_i,
    input  logic [95:0]      cmd_iv_i,
    input  logic [LEN_W-1:0] cmd_aad_len_i,
    input  logic [LEN_W-1:0] cmd_pt_len_i,
    input  logic             blk_valid_i,
    output logic             blk_ready_o,
    input  logic [127:0]     blk_data_i,
    output logic             gcm_key_vld_o,
    output logic [127:0]     gcm_key_o,
    output logic             gcm_iv_vld_o,
    output logic             gcm_aad_vld_o,
    output logic             gcm_data_vld_o,
    output logic             gcm_end_o,
    output logic [127:0]     gcm_data_o,
    input  logic             gcm_data_vld_i,
    input  logic             gcm_tag_vld_i,
    input  logic [127:0]     gcm_data_i,
    output logic             out_vld_o,
    output logic [127:0]     out_data_o,
    output logic             tag_vld_o,
    output logic [127:0]     tag_o,
    output logic             timeout_o,
    output logic             err_o
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_AAD  = 2'd1;
    localparam logic [1:0]  S_DATA = 2'd2;
    localparam logic [1:0]  S_WAIT = 2'd3;
    localparam logic [31:0] TO_LIM = 32'(TAG_TIMEOUT - 1);
    localparam logic [LEN_W-1:0] FULL_BLK = LEN_W'(16);

    // Bytes consumed by one block: min(rem,16)
    function automatic logic [4:0] take_bytes(input logic [LEN_W-1:0] rem);
        return (rem >= FULL_BLK) ? 5'd16 : rem[4:0];
    endfunction

    // Keep bytes 0..n-1 (byte 0 at the top), zero the rest
    function automatic logic [127:0] mask_bytes(input logic [127:0] d, input logic [4:0] n);
        logic [127:0] r;
        r = d;
        for (int i = 0; i < 16; i++) begin
            if (i >= int'(n)) r[127-8*i -: 8] = 8'h00;
        end
        return r;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] rem_aad_q, rem_aad_d, rem_pt_q, rem_pt_d, rem_out_q, rem_out_d;
    logic [31:0]      timer_q, timer_d;
    logic             cmd_rdy_q, cmd_rdy_d, blk_rdy_q, blk_rdy_d;
    logic             key_vld_q, key_vld_d, iv_vld_q, iv_vld_d;
    logic             aad_vld_q, aad_vld_d, dat_vld_q, dat_vld_d, end_q, end_d;
    logic [127:0]     key_q, key_d, gdat_q, gdat_d;
    logic             out_vld_q, out_vld_d, tag_vld_q, tag_vld_d;
    logic [127:0]     out_dat_q, out_dat_d, tag_q, tag_d;
    logic             tmo_q, tmo_d, err_q, err_d;
    logic             cmd_hs, blk_hs;
    logic [4:0]       n_in, n_out;

    assign cmd_hs = cmd_valid_i && cmd_rdy_q;
    assign blk_hs = blk_valid_i && blk_rdy_q;

    // Next-state: job sequencing, output masking, tag capture and timeout
    always_comb begin
        state_d   = state_q;
        rem_aad_d = rem_aad_q;
        rem_pt_d  = rem_pt_q;
        rem_out_d = rem_out_q;
        timer_d   = timer_q;
        key_d     = key_q;
        gdat_d    = gdat_q;
        out_dat_d = out_dat_q;
        tag_d     = tag_q;
        key_vld_d = 1'b0;
        iv_vld_d  = 1'b0;
        aad_vld_d = 1'b0;
        dat_vld_d = 1'b0;
        end_d     = 1'b0;
        out_vld_d = 1'b0;
        tag_vld_d = 1'b0;
        tmo_d     = 1'b0;
        err_d     = 1'b0;
        n_in      = 5'd0;
        n_out     = 5'd0;

        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    rem_aad_d = cmd_aad_len_i;
                    rem_pt_d  = cmd_pt_len_i;
                    rem_out_d = cmd_pt_len_i;
                    key_vld_d = 1'b1;
                    iv_vld_d  = 1'b1;
                    key_d     = cmd_key_i;
                    gdat_d    = {cmd_iv_i, 32'h0};
                    timer_d   = 32'd0;
                    if (cmd_aad_len_i != '0)     state_d = S_AAD;
                    else if (cmd_pt_len_i != '0) state_d = S_DATA;
                    else begin
                        state_d = S_WAIT;
                        end_d   = 1'b1;
                    end
                end
            end
            S_AAD: begin
                if (blk_hs) begin
                    n_in      = take_bytes(rem_aad_q);
                    gdat_d    = mask_bytes(blk_data_i, n_in);
                    aad_vld_d = 1'b1;
                    rem_aad_d = rem_aad_q - LEN_W'(n_in);
                    if (rem_aad_q <= FULL_BLK) begin
                        timer_d = 32'd0;
                        if (rem_pt_q != '0) state_d = S_DATA;
                        else begin
                            state_d = S_WAIT;
                            end_d   = 1'b1;
                        end
                    end
                end
                if (gcm_tag_vld_i) err_d = 1'b1;
            end
            S_DATA: begin
                if (blk_hs) begin
                    n_in      = take_bytes(rem_pt_q);
                    gdat_d    = mask_bytes(blk_data_i, n_in);
                    dat_vld_d = 1'b1;
                    rem_pt_d  = rem_pt_q - LEN_W'(n_in);
                    if (rem_pt_q <= FULL_BLK) begin
                        state_d = S_WAIT;
                        end_d   = 1'b1;
                        timer_d = 32'd0;
                    end
                end
                if (gcm_tag_vld_i) err_d = 1'b1;
            end
            default: begin
                timer_d = timer_q + 32'd1;
                if (gcm_tag_vld_i) begin
                    tag_d     = gcm_data_i;
                    tag_vld_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (TAG_TIMEOUT != 0 && timer_q == TO_LIM) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase

        // Core output blocks are trimmed to the payload length; extras are flagged
        if (state_q != S_IDLE && gcm_data_vld_i) begin
            if (rem_out_q == '0) begin
                err_d = 1'b1;
            end else begin
                n_out     = take_bytes(rem_out_q);
                out_dat_d = mask_bytes(gcm_data_i, n_out);
                out_vld_d = 1'b1;
                rem_out_d = rem_out_q - LEN_W'(n_out);
            end
        end

        cmd_rdy_d = (state_d == S_IDLE);
        blk_rdy_d = (state_d == S_AAD) || (state_d == S_DATA);
    end

    // State and registered outputs; reset clears everything including the held tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rem_aad_q <= '0;
            rem_pt_q  <= '0;
            rem_out_q <= '0;
            timer_q   <= '0;
            cmd_rdy_q <= 1'b0;
            blk_rdy_q <= 1'b0;
            key_vld_q <= 1'b0;
            iv_vld_q  <= 1'b0;
            aad_vld_q <= 1'b0;
            dat_vld_q <= 1'b0;
            end_q     <= 1'b0;
            key_q     <= '0;
            gdat_q    <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            tag_vld_q <= 1'b0;
            tag_q     <= '0;
            tmo_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_aad_q <= rem_aad_d;
            rem_pt_q  <= rem_pt_d;
            rem_out_q <= rem_out_d;
            timer_q   <= timer_d;
            cmd_rdy_q <= cmd_rdy_d;
            blk_rdy_q <= blk_rdy_d;
            key_vld_q <= key_vld_d;
            iv_vld_q  <= iv_vld_d;
            aad_vld_q <= aad_vld_d;
            dat_vld_q <= dat_vld_d;
            end_q     <= end_d;
            key_q     <= key_d;
            gdat_q    <= gdat_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            tag_vld_q <= tag_vld_d;
            tag_q     <= tag_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    assign cmd_ready_o    = cmd_rdy_q;
    assign blk_ready_o    = blk_rdy_q;
    assign gcm_key_vld_o  = key_vld_q;
    assign gcm_key_o      = key_q;
    assign gcm_iv_vld_o   = iv_vld_q;
    assign gcm_aad_vld_o  = aad_vld_q;
    assign gcm_data_vld_o = dat_vld_q;
    assign gcm_end_o      = end_q;
    assign gcm_data_o     = gdat_q;
    assign out_vld_o      = out_vld_q;
    assign out_data_o     = out_dat_q;
    assign tag_vld_o      = tag_vld_q;
    assign tag_o          = tag_q;
    assign timeout_o      = tmo_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_gcm_job_seq.sv
// Directed bench for gcm_job_seq with a hand-driven core on the gcm_* inputs.
// Each scenario task drives stimulus and compares outputs 1 time unit after the clock edge.
// A single instance uses TAG_TIMEOUT=16 so the timeout case stays short.
module tb_gcm_job_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [127:0] cmd_key_i;
    logic [95:0]  cmd_iv_i;
    logic [15:0]  cmd_aad_len_i;
    logic [15:0]  cmd_pt_len_i;
    logic         blk_valid_i;
    logic         blk_ready_o;
    logic [127:0] blk_data_i;
    logic         gcm_key_vld_o;
    logic [127:0] gcm_key_o;
    logic         gcm_iv_vld_o;
    logic         gcm_aad_vld_o;
    logic         gcm_data_vld_o;
    logic         gcm_end_o;
    logic [127:0] gcm_data_o;
    logic         gcm_data_vld_i;
    logic         gcm_tag_vld_i;
    logic [127:0] gcm_data_i;
    logic         out_vld_o;
    logic [127:0] out_data_o;
    logic         tag_vld_o;
    logic [127:0] tag_o;
    logic         timeout_o;
    logic         err_o;

    logic [4:0]   stb;
    int           checks;
    int           failures;

    logic [127:0] j2_in  [6];
    logic [127:0] j2_exp [6];

    localparam logic [127:0] KEY1 = 128'h11754cd72aec309bf52f7687212e8957;
    localparam logic [95:0]  IV1  = 96'h3c819d9a9bed087615030b65;
    localparam logic [127:0] KEY2 = 128'hfe47fcce5fc32665d2ae399e4eec72ba;
    localparam logic [95:0]  IV2  = 96'h5adb9609dbaeb58cbd6e7275;
    localparam logic [127:0] ONES = {128{1'b1}};

    always #5 clk = ~clk;

    assign stb = {gcm_key_vld_o, gcm_iv_vld_o, gcm_aad_vld_o, gcm_data_vld_o, gcm_end_o};

    gcm_job_seq #(.LEN_W(16), .TAG_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_key_i(cmd_key_i),
        .cmd_iv_i(cmd_iv_i), .cmd_aad_len_i(cmd_aad_len_i), .cmd_pt_len_i(cmd_pt_len_i),
        .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
        .gcm_key_vld_o(gcm_key_vld_o), .gcm_key_o(gcm_key_o), .gcm_iv_vld_o(gcm_iv_vld_o),
        .gcm_aad_vld_o(gcm_aad_vld_o), .gcm_data_vld_o(gcm_data_vld_o), .gcm_end_o(gcm_end_o),
        .gcm_data_o(gcm_data_o), .gcm_data_vld_i(gcm_data_vld_i), .gcm_tag_vld_i(gcm_tag_vld_i),
        .gcm_data_i(gcm_data_i), .out_vld_o(out_vld_o), .out_data_o(out_data_o),
        .tag_vld_o(tag_vld_o), .tag_o(tag_o), .timeout_o(timeout_o), .err_o(err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [127:0] key, input logic [95:0] iv,
                             input logic [15:0] aad, input logic [15:0] pt);
        cmd_valid_i   = 1'b1;
        cmd_key_i     = key;
        cmd_iv_i      = iv;
        cmd_aad_len_i = aad;
        cmd_pt_len_i  = pt;
        step();
        cmd_valid_i   = 1'b0;
    endtask

    task automatic core_tag(input logic [127:0] t);
        gcm_tag_vld_i = 1'b1;
        gcm_data_i    = t;
        step();
        gcm_tag_vld_i = 1'b0;
        gcm_data_i    = '0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({cmd_ready_o, blk_ready_o, stb, gcm_key_o, gcm_data_o, out_vld_o, out_data_o,
             tag_vld_o, tag_o, timeout_o, err_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: some output nonzero, tag_o=%h gcm_data_o=%h", tag_o, gcm_data_o);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (cmd_ready_o !== 1'b1 || blk_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: cmd_ready=%b blk_ready=%b required 1/0", cmd_ready_o, blk_ready_o);
        end
    endtask

    task automatic test_empty_job(input logic [127:0] t);
        start_job(KEY1, IV1, 16'd0, 16'd0);
        checks++;
        if (stb !== 5'b11001 || gcm_key_o !== KEY1 ||
            gcm_data_o !== 128'h3c819d9a9bed087615030b6500000000 || cmd_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL empty_keyiv: stb=%b key=%h data=%h rdy=%b required 11001 %h %h 0",
                     stb, gcm_key_o, gcm_data_o, cmd_ready_o, KEY1, {IV1, 32'h0});
        end
        core_tag(t);
        checks++;
        if (tag_vld_o !== 1'b1 || tag_o !== t || err_o !== 1'b0) begin
            failures++;
            $display("FAIL empty_tag: tag_vld=%b tag=%h err=%b required 1 %h 0", tag_vld_o, tag_o, err_o, t);
        end
        step();
        checks++;
        if (tag_vld_o !== 1'b0 || tag_o !== t || cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL empty_after: tag_vld=%b tag=%h rdy=%b required 0 %h 1", tag_vld_o, tag_o, cmd_ready_o, t);
        end
    endtask

    task automatic test_job_20_51();
        logic [4:0]   exp_stb;
        logic [127:0] exp_out;
        start_job(KEY2, IV2, 16'd20, 16'd51);
        checks++;
        if (stb !== 5'b11000 || gcm_data_o !== {IV2, 32'h0} || blk_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL j2_keyiv: stb=%b data=%h blk_rdy=%b required 11000 %h 1", stb, gcm_data_o, blk_ready_o, {IV2, 32'h0});
        end
        for (int i = 0; i < 6; i++) begin
            blk_valid_i = 1'b1;
            blk_data_i  = j2_in[i];
            step();
            exp_stb = {2'b00, i < 2, i >= 2, i == 5};
            checks++;
            if (stb !== exp_stb || gcm_data_o !== j2_exp[i]) begin
                failures++;
                $display("FAIL j2_blk%0d: stb=%b data=%h required %b %h", i, stb, gcm_data_o, exp_stb, j2_exp[i]);
            end
        end
        blk_valid_i = 1'b0;
        checks++;
        if (blk_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL j2_blk_ready_off: blk_ready=%b required 0", blk_ready_o);
        end
        for (int i = 0; i < 4; i++) begin
            gcm_data_vld_i = 1'b1;
            gcm_data_i     = ONES;
            step();
            exp_out = (i == 3) ? 128'hffffff00000000000000000000000000 : ONES;
            checks++;
            if (out_vld_o !== 1'b1 || out_data_o !== exp_out || err_o !== 1'b0) begin
                failures++;
                $display("FAIL j2_out%0d: vld=%b data=%h err=%b required 1 %h 0", i, out_vld_o, out_data_o, err_o, exp_out);
            end
        end
        gcm_data_vld_i = 1'b0;
        core_tag(128'h0f0e0d0c0b0a09080706050403020100);
        checks++;
        if (tag_vld_o !== 1'b1 || tag_o !== 128'h0f0e0d0c0b0a09080706050403020100 || out_vld_o !== 1'b0) begin
            failures++;
            $display("FAIL j2_tag: tag_vld=%b tag=%h out_vld=%b", tag_vld_o, tag_o, out_vld_o);
        end
    endtask

    task automatic test_gaps();
        int           idx;
        logic         v;
        logic [4:0]   exp_stb;
        idx = 0;
        start_job(KEY2, IV2, 16'd20, 16'd51);
        for (int c = 0; c < 12; c++) begin
            v           = (c % 2 == 0) && (idx < 6);
            blk_valid_i = v;
            blk_data_i  = (idx < 6) ? j2_in[idx] : '0;
            step();
            exp_stb = v ? {2'b00, idx < 2, idx >= 2, idx == 5} : 5'b00000;
            checks++;
            if (stb !== exp_stb || (v && gcm_data_o !== j2_exp[idx])) begin
                failures++;
                $display("FAIL gaps_c%0d: stb=%b data=%h required %b %h", c, stb, gcm_data_o, exp_stb, (idx < 6) ? j2_exp[idx] : '0);
            end
            if (v) idx++;
        end
        blk_valid_i = 1'b0;
        core_tag(128'h1);
        checks++;
        if (tag_vld_o !== 1'b1 || tag_o !== 128'h1) begin
            failures++;
            $display("FAIL gaps_tag: tag_vld=%b tag=%h required 1 1", tag_vld_o, tag_o);
        end
    endtask

    task automatic test_timeout();
        start_job(KEY1, IV1, 16'd0, 16'd0);
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (timeout_o !== (k == 16)) begin
                failures++;
                $display("FAIL timeout_k%0d: timeout=%b required %b", k, timeout_o, (k == 16));
            end
        end
        step();
        checks++;
        if (timeout_o !== 1'b0 || cmd_ready_o !== 1'b1 || tag_vld_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_after: timeout=%b rdy=%b tag_vld=%b required 0 1 0", timeout_o, cmd_ready_o, tag_vld_o);
        end
    endtask

    task automatic test_aad_only_and_surplus();
        core_tag(128'h5);
        checks++;
        if (err_o !== 1'b0 || tag_vld_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_tag: err=%b tag_vld=%b required 0 0", err_o, tag_vld_o);
        end
        start_job(KEY2, IV2, 16'd32, 16'd0);
        for (int i = 0; i < 2; i++) begin
            blk_valid_i = 1'b1;
            blk_data_i  = ONES;
            step();
            checks++;
            if (stb !== {4'b0010, i == 1} || gcm_data_o !== ONES) begin
                failures++;
                $display("FAIL aad32_blk%0d: stb=%b data=%h required %b all-ones", i, stb, gcm_data_o, {4'b0010, i == 1});
            end
        end
        blk_valid_i = 1'b0;
        core_tag(128'h2);
        start_job(KEY2, IV2, 16'd0, 16'd51);
        core_tag(128'h3);
        checks++;
        if (err_o !== 1'b1 || tag_vld_o !== 1'b0 || blk_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL data_tag_err: err=%b tag_vld=%b blk_rdy=%b required 1 0 1", err_o, tag_vld_o, blk_ready_o);
        end
        for (int i = 0; i < 4; i++) begin
            blk_valid_i = 1'b1;
            blk_data_i  = j2_in[i + 2];
            step();
            checks++;
            if (stb !== {4'b0001, i == 3} || gcm_data_o !== j2_exp[i + 2]) begin
                failures++;
                $display("FAIL pt51_blk%0d: stb=%b data=%h required %b %h", i, stb, gcm_data_o, {4'b0001, i == 3}, j2_exp[i + 2]);
            end
        end
        blk_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            gcm_data_vld_i = 1'b1;
            gcm_data_i     = ONES;
            step();
            checks++;
            if (out_vld_o !== (i < 4) || err_o !== (i == 4)) begin
                failures++;
                $display("FAIL surplus_out%0d: out_vld=%b err=%b required %b %b", i, out_vld_o, err_o, (i < 4), (i == 4));
            end
        end
        gcm_data_vld_i = 1'b0;
        gcm_data_i     = '0;
        core_tag(128'h4);
        checks++;
        if (tag_vld_o !== 1'b1 || tag_o !== 128'h4) begin
            failures++;
            $display("FAIL surplus_tag: tag_vld=%b tag=%h required 1 4", tag_vld_o, tag_o);
        end
    endtask

    task automatic test_reset_mid_job();
        start_job(KEY2, IV2, 16'd0, 16'd51);
        blk_valid_i = 1'b1;
        blk_data_i  = j2_in[2];
        step();
        checks++;
        if (gcm_data_vld_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_reset: data_vld=%b required 1", gcm_data_vld_o);
        end
        blk_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready_o, blk_ready_o, stb, gcm_key_o, gcm_data_o, out_vld_o, out_data_o,
             tag_vld_o, tag_o, timeout_o, err_o} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: stb=%b data=%h tag=%h blk_rdy=%b", stb, gcm_data_o, tag_o, blk_ready_o);
        end
        #2;
        rst_n = 1'b1;
        step();
        test_empty_job(128'habcdef);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        cmd_valid_i    = 1'b0;
        cmd_key_i      = '0;
        cmd_iv_i       = '0;
        cmd_aad_len_i  = '0;
        cmd_pt_len_i   = '0;
        blk_valid_i    = 1'b0;
        blk_data_i     = '0;
        gcm_data_vld_i = 1'b0;
        gcm_tag_vld_i  = 1'b0;
        gcm_data_i     = '0;

        j2_in[0]  = 128'h00112233445566778899aabbccddeeff;
        j2_in[1]  = 128'hc2aeba5affffffffffffffffffffffff;
        j2_in[2]  = 128'h0123456789abcdef0123456789abcdef;
        j2_in[3]  = 128'hfedcba9876543210fedcba9876543210;
        j2_in[4]  = 128'h55aa55aa55aa55aa55aa55aa55aa55aa;
        j2_in[5]  = 128'hbea063ffffffffffffffffffffffffff;
        j2_exp[0] = j2_in[0];
        j2_exp[1] = 128'hc2aeba5a000000000000000000000000;
        j2_exp[2] = j2_in[2];
        j2_exp[3] = j2_in[3];
        j2_exp[4] = j2_in[4];
        j2_exp[5] = 128'hbea06300000000000000000000000000;

        test_reset();
        test_empty_job(128'hd0d1d2d3d4d5d6d7d8d9dadbdcdddedf);
        test_job_20_51();
        test_gaps();
        test_timeout();
        test_aad_only_and_surplus();
        test_reset_mid_job();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
